// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals for the memory port arbiter.
// Arbiter side uses modport slave, the core/memory environment uses master.
// Widths follow the address/data parameters of the arbiter instance.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store.
// Latency: grant is combinational; read data returns MEM_LAT cycles after grant.
// Backpressure: requesters hold req until gnt; returns are never stalled.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic               clk,
    input  logic               clr,
    mem_port_arbiter_if.slave  bus
);
    // last = 0 after a fetch grant, 1 after a data grant; reset favours fetch
    logic               last;
    logic               if_gnt_w;
    logic               d_gnt_w;
    logic               rd_push;
    logic               rd_id;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               sel_we;
    // tag pipeline: stage MEM_LAT-1 lines up with mem_rdata
    logic [MEM_LAT-1:0] tag_vld;
    logic [MEM_LAT-1:0] tag_id;

    // Grant decision and memory-side mux; idle cycles drive zeros to the macro
    always_comb begin
        if_gnt_w  = ~clr & bus.if_req & (~bus.d_req | last);
        d_gnt_w   = ~clr & bus.d_req & ~if_gnt_w;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (if_gnt_w) begin
            sel_addr = bus.if_addr;
        end else if (d_gnt_w) begin
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            sel_we    = bus.d_we;
        end
        rd_push = if_gnt_w | (d_gnt_w & ~bus.d_we);
        rd_id   = d_gnt_w & ~bus.d_we;
    end

    assign bus.if_gnt    = if_gnt_w;
    assign bus.d_gnt     = d_gnt_w;
    assign bus.mem_en    = if_gnt_w | d_gnt_w;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    // Round-robin pointer and return-tag shift register; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (clr) begin
            last    <= 1'b1;
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            if (if_gnt_w) begin
                last <= 1'b0;
            end else if (d_gnt_w) begin
                last <= 1'b1;
            end
            tag_vld[0] <= rd_push;
            tag_id[0]  <= rd_id;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign bus.if_rvalid = tag_vld[MEM_LAT-1] & ~tag_id[MEM_LAT-1];
    assign bus.d_rvalid  = tag_vld[MEM_LAT-1] &  tag_id[MEM_LAT-1];
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (read latency 2 and 3) against
// simple memory models that return addr ^ 0xA5A5 after the read latency.
module tb_mem_port_arbiter;
    logic clk;
    logic clr;
    logic clr_b;
    int   n_chk;
    int   n_bad;

    mem_port_arbiter_if #(.AW(16), .DW(16)) a ();
    mem_port_arbiter_if #(.AW(16), .DW(16)) b ();

    mem_port_arbiter #(.MEM_LAT(2), .AW(16), .DW(16)) u_a (
        .clk (clk),
        .clr (clr),
        .bus (a)
    );

    mem_port_arbiter #(.MEM_LAT(3), .AW(16), .DW(16)) u_b (
        .clk (clk),
        .clr (clr_b),
        .bus (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory models: address delayed by the read latency, then scrambled
    logic [15:0] pa [0:1];
    logic [15:0] pb [0:2];
    always @(posedge clk) begin
        pa[0] <= a.mem_addr;
        pa[1] <= pa[0];
        pb[0] <= b.mem_addr;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign a.mem_rdata = pa[1] ^ 16'hA5A5;
    assign b.mem_rdata = pb[2] ^ 16'hA5A5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [15:0] ea;
        n_chk = 0;
        n_bad = 0;
        a.if_req = 1'b1; a.if_addr = 16'h0100;
        a.d_req = 1'b1;  a.d_we = 1'b0; a.d_addr = 16'h0200; a.d_wdata = 16'h0;
        b.if_req = 1'b0; b.if_addr = 16'h0;
        b.d_req = 1'b0;  b.d_we = 1'b0; b.d_addr = 16'h0; b.d_wdata = 16'h0;
        clr = 1'b1;
        clr_b = 1'b1;

        // reset held for two edges with both requests asserted
        #1;
        chk("rst0_if_gnt", a.if_gnt, 0);
        chk("rst0_d_gnt", a.d_gnt, 0);
        chk("rst0_mem_en", a.mem_en, 0);
        @(negedge clk); #1;
        chk("rst1_if_gnt", a.if_gnt, 0);
        chk("rst1_d_gnt", a.d_gnt, 0);
        chk("rst1_mem_en", a.mem_en, 0);
        chk("rst1_mem_we", a.mem_we, 0);
        chk("rst1_if_rvalid", a.if_rvalid, 0);
        chk("rst1_d_rvalid", a.d_rvalid, 0);
        chk("rst1_b_rvalid", {b.if_rvalid, b.d_rvalid}, 0);

        // contention for six cycles: F,D,F,D,F,D then returns drain
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clr = 1'b0;
            clr_b = 1'b0;
            a.if_req = (c < 6);
            a.d_req  = (c < 6);
            #1;
            chk($sformatf("cont_if_gnt[%0d]", c), a.if_gnt, (c < 6) && (c % 2 == 0));
            chk($sformatf("cont_d_gnt[%0d]", c), a.d_gnt, (c < 6) && (c % 2 == 1));
            ea = (c >= 6) ? 16'h0 : ((c % 2 == 0) ? 16'h0100 : 16'h0200);
            chk($sformatf("cont_mem_addr[%0d]", c), a.mem_addr, ea);
            chk($sformatf("cont_if_rvalid[%0d]", c), a.if_rvalid, (c >= 2) && (c % 2 == 0));
            chk($sformatf("cont_d_rvalid[%0d]", c), a.d_rvalid, (c >= 2) && (c % 2 == 1));
            if (c >= 2 && c % 2 == 0) chk($sformatf("cont_if_rdata[%0d]", c), a.if_rdata, 16'hA4A5);
            if (c >= 2 && c % 2 == 1) chk($sformatf("cont_d_rdata[%0d]", c), a.d_rdata, 16'hA7A5);
        end

        // fetch stream, addresses 0..3, data returns two cycles later
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            a.if_req  = (c < 4);
            a.if_addr = (c < 4) ? 16'(c) : 16'h0;
            #1;
            chk($sformatf("fs_if_gnt[%0d]", c), a.if_gnt, c < 4);
            chk($sformatf("fs_mem_addr[%0d]", c), a.mem_addr, (c < 4) ? c : 0);
            chk($sformatf("fs_if_rvalid[%0d]", c), a.if_rvalid, c >= 2);
            chk($sformatf("fs_d_rvalid[%0d]", c), a.d_rvalid, 0);
            if (c == 2) chk("fs_rdata0", a.if_rdata, 16'hA5A5);
            if (c == 3) chk("fs_rdata1", a.if_rdata, 16'hA5A4);
            if (c == 4) chk("fs_rdata2", a.if_rdata, 16'hA5A7);
            if (c == 5) chk("fs_rdata3", a.if_rdata, 16'hA5A6);
        end

        // single write, then idle cycles with stale data inputs
        @(negedge clk);
        a.d_req = 1'b1; a.d_we = 1'b1; a.d_addr = 16'h0010; a.d_wdata = 16'h1234;
        #1;
        chk("wr_d_gnt", a.d_gnt, 1);
        chk("wr_if_gnt", a.if_gnt, 0);
        chk("wr_mem_en", a.mem_en, 1);
        chk("wr_mem_we", a.mem_we, 1);
        chk("wr_mem_addr", a.mem_addr, 16'h0010);
        chk("wr_mem_wdata", a.mem_wdata, 16'h1234);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a.d_req = 1'b0;
            #1;
            chk($sformatf("wr_idle_en[%0d]", c), a.mem_en, 0);
            chk($sformatf("wr_idle_we[%0d]", c), a.mem_we, 0);
            chk($sformatf("wr_idle_addr[%0d]", c), a.mem_addr, 0);
            chk($sformatf("wr_idle_wdata[%0d]", c), a.mem_wdata, 0);
            chk($sformatf("wr_idle_rvalid[%0d]", c), {a.if_rvalid, a.d_rvalid}, 0);
        end
        a.d_we = 1'b0;

        // withdrawn data request; the following contention must go to data
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            a.if_req  = (c == 0) || (c == 2) || (c == 3);
            a.if_addr = 16'h0040;
            a.d_req   = (c == 0) || (c == 2);
            a.d_addr  = 16'h0050;
            #1;
            chk($sformatf("wd_if_gnt[%0d]", c), a.if_gnt, (c == 0) || (c == 3));
            chk($sformatf("wd_d_gnt[%0d]", c), a.d_gnt, c == 2);
            chk($sformatf("wd_if_rvalid[%0d]", c), a.if_rvalid, (c == 2) || (c == 5));
            chk($sformatf("wd_d_rvalid[%0d]", c), a.d_rvalid, c == 4);
            if (c == 2) chk("wd_if_rdata0", a.if_rdata, 16'hA5E5);
            if (c == 4) chk("wd_d_rdata", a.d_rdata, 16'hA5F5);
            if (c == 5) chk("wd_if_rdata1", a.if_rdata, 16'hA5E5);
        end
        a.if_req = 1'b0;
        a.d_req  = 1'b0;

        // latency-3 instance: two reads in flight, then a reset pulse drops them;
        // a data request held across the reset is served after it
        @(negedge clk);
        b.if_req = 1'b1; b.if_addr = 16'h0005;
        #1;
        chk("fl_if_gnt", b.if_gnt, 1);
        @(negedge clk);
        b.if_req = 1'b0;
        b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 16'h0006;
        #1;
        chk("fl_d_gnt", b.d_gnt, 1);
        @(negedge clk);
        clr_b = 1'b1;
        #1;
        chk("fl_clr_d_gnt", b.d_gnt, 0);
        chk("fl_clr_mem_en", b.mem_en, 0);
        for (int c = 3; c < 8; c++) begin
            @(negedge clk);
            clr_b = 1'b0;
            b.d_req = (c == 3);
            #1;
            chk($sformatf("fl_d_gnt[%0d]", c), b.d_gnt, c == 3);
            chk($sformatf("fl_if_rvalid[%0d]", c), b.if_rvalid, 0);
            chk($sformatf("fl_d_rvalid[%0d]", c), b.d_rvalid, c == 6);
            if (c == 6) chk("fl_d_rdata", b.d_rdata, 16'hA5A3);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port 16-bit memory of the MIPS-based microprocessor between the instruction-fetch requester and the load/store requester. Issues at most one memory access per cycle with round-robin fairness and supports pipelined reads with a fixed memory read latency. Routes each returned read word back to the requester that issued it. Sits between the processor core and the memory macro; the memory macro has no knowledge of requesters.

## Interface
- `MEM_LAT`, 1: memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..4
- `AW`, 16: address width
- `DW`, 16: data width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch read request
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DW  fetch read data
- `d_req`  in  1  data access request
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  data read data valid (reads only)
- `d_rdata`  out  DW  data read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after read strobe

## Operation
- Requester holds `req` and all its request signals stable until it sees `gnt` high at a rising edge. Deasserting `req` before grant is legal and withdraws the request.
- Grant is combinational from the current `req` values and the `last` state bit. At most one of `if_gnt` and `d_gnt` is high.
  - Only one requester asserts `req`: that requester is granted.
  - Both assert `req`: the requester not granted most recently is granted.
  - `last` updates on every grant: 0 after a fetch grant, 1 after a data grant.
- Memory outputs in the grant cycle:
  - `mem_en` = `if_gnt | d_gnt`.
  - `mem_we` = `d_gnt & d_we`.
  - `mem_addr` and `mem_wdata` come from the granted requester.
- When `mem_en` is 0, `mem_addr`, `mem_wdata` and `mem_we` are 0.
- Return tag pipeline:
  - Each read grant pushes a 2-bit tag into a `MEM_LAT`-deep shift register: {valid, 0 = fetch / 1 = data}. Writes and idle cycles push {0,0}.
  - At the output stage, `if_rvalid` = valid & ~id and `d_rvalid` = valid & id.
  - `if_rdata` and `d_rdata` both equal `mem_rdata`, and are meaningful only while the matching `rvalid` is high.
- Up to `MEM_LAT` reads are outstanding. Return order equals issue order. The arbiter has no backpressure on returns; requesters always accept returned data.
- Writes produce no response. A write is complete at its grant edge.

## Timing
- Reset (`clr` high at a rising edge):
  - `last` <= 1, so fetch wins the first contention.
  - The tag pipeline is cleared.
- While `clr` is high:
  - `if_gnt`, `d_gnt`, `mem_en` and `mem_we` are forced to 0.
  - `if_rvalid` and `d_rvalid` are 0 from the first edge with `clr` high.
- Reset mid-operation: in-flight reads are dropped and never produce `rvalid`. Requests still held after `clr` falls are arbitrated normally.
- Read latency: a grant in cycle N gives `rvalid` high in cycle N+`MEM_LAT`.
- Throughput: one access per cycle.
  - A single requester holding `req` is granted every cycle.
  - Under continuous contention, grants alternate F, D, F, D...
- Simultaneous events: a new grant and a return of an older read in the same cycle are independent. Both occur.

## Test plan
- Reset: `clr`=1 for 2 cycles with both `req`=1 -> `if_gnt`=`d_gnt`=`mem_en`=0, both `rvalid`=0. After release, the first cycle gives `if_gnt`=1.
- Fetch stream, `MEM_LAT`=2: `if_req` held with addresses 0x0000..0x0003 and the memory model returning addr^0xA5A5 -> grants on 4 consecutive cycles. `if_rvalid` runs 2 cycles later with data 0xA5A5, 0xA5A4, 0xA5A7, 0xA5A6.
- Contention: both `req` held for 6 cycles -> grant order F,D,F,D,F,D. Each `rvalid` pulse is routed to the correct port in issue order.
- Data write: `d_req`=1, `d_we`=1, `d_addr`=0x0010, `d_wdata`=0x1234 -> `mem_en`=`mem_we`=1 with that address/data in the grant cycle. No `d_rvalid` follows.
- Reset with reads in flight (`MEM_LAT`=3): two reads granted, then `clr` pulsed one cycle later -> no `rvalid` ever appears for those reads.
- Withdrawn request: `d_req` high for one cycle while fetch wins, then dropped -> `d_gnt` is never asserted and `last` remains 0.
